// File: rtl/freq_pkg.sv
// Shared constants and FSM state type for the frequency gate counter.
package freq_pkg;

  localparam int unsigned FREQ_W            = 14;
  localparam int unsigned MAX_COUNT_DEFAULT = 9999;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    MEASURE
  } state_t;

endpackage

// File: rtl/freq_gate_counter_if.sv
// Measurement control/result bundle between the gate counter and its consumers.
// The overflow signal exists only when FREQ_OVERFLOW_EN is defined.
interface freq_gate_counter_if;
  import freq_pkg::*;

  logic              enable;
  logic              signal;
  logic [FREQ_W-1:0] frequency;
  logic              valid;
`ifdef FREQ_OVERFLOW_EN
  logic              overflow;
`endif

  modport master (
    output enable,
    output signal,
    input  frequency,
    input  valid
`ifdef FREQ_OVERFLOW_EN
    ,
    input  overflow
`endif
  );

  modport slave (
    input  enable,
    input  signal,
    output frequency,
    output valid
`ifdef FREQ_OVERFLOW_EN
    ,
    output overflow
`endif
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Metastability synchroniser followed by a single-cycle rising-edge detector.
// Reusable for any asynchronous board input.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and publishes
// a saturated result with a one-cycle valid pulse. Optional macro: FREQ_OVERFLOW_EN.
module freq_gate_counter
  import freq_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned MAX_COUNT   = MAX_COUNT_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                clock,
    input logic                reset,
    freq_gate_counter_if.slave bus
);

  localparam int unsigned       GateW     = $clog2(GATE_CYCLES);
  localparam int unsigned       PrimeW    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [GateW-1:0]  GateLast  = GateW'(GATE_CYCLES - 1);
  localparam logic [PrimeW-1:0] PrimeLast = PrimeW'(SYNC_STAGES);
  localparam logic [FREQ_W-1:0] MaxCount  = FREQ_W'(MAX_COUNT);

  state_t              state_q, state_d;
  logic [GateW-1:0]    gate_q, gate_d;
  logic [FREQ_W-1:0]   edge_q, edge_d;
  logic [PrimeW-1:0]   prime_q, prime_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                valid_q, valid_d;
  logic                rise;
  logic                at_max;
`ifdef FREQ_OVERFLOW_EN
  // sat_q remembers that a detection was dropped at the ceiling this window.
  logic                sat_q, sat_d;
  logic                ovf_q, ovf_d;
`endif

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .async_in  (bus.signal),
    .rise_pulse(rise)
  );

  assign at_max = (edge_q == MaxCount);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    prime_d = prime_q;
    freq_d  = freq_q;
    valid_d = 1'b0;
`ifdef FREQ_OVERFLOW_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        gate_d  = '0;
        edge_d  = '0;
        prime_d = '0;
`ifdef FREQ_OVERFLOW_EN
        sat_d   = 1'b0;
`endif
        if (bus.enable) begin
          state_d = PRIME;
        end
      end

      PRIME: begin
        gate_d = '0;
        edge_d = '0;
`ifdef FREQ_OVERFLOW_EN
        sat_d  = 1'b0;
`endif
        if (!bus.enable) begin
          state_d = IDLE;
          prime_d = '0;
        end else if (prime_q == PrimeLast) begin
          state_d = MEASURE;
          prime_d = '0;
        end else begin
          prime_d = prime_q + PrimeW'(1);
        end
      end

      MEASURE: begin
        if (!bus.enable) begin
          // Partial window is dropped; published result stays untouched.
          state_d = IDLE;
          gate_d  = '0;
          edge_d  = '0;
`ifdef FREQ_OVERFLOW_EN
          sat_d   = 1'b0;
`endif
        end else if (gate_q == GateLast) begin
          // A detection in the closing cycle belongs to the closing window.
          freq_d  = at_max ? MaxCount : edge_q + FREQ_W'(rise);
          valid_d = 1'b1;
          gate_d  = '0;
          edge_d  = '0;
`ifdef FREQ_OVERFLOW_EN
          ovf_d   = sat_q | (rise & at_max);
          sat_d   = 1'b0;
`endif
        end else begin
          gate_d = gate_q + GateW'(1);
          if (rise) begin
            if (!at_max) begin
              edge_d = edge_q + FREQ_W'(1);
            end
`ifdef FREQ_OVERFLOW_EN
            else begin
              sat_d = 1'b1;
            end
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      prime_q <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
`ifdef FREQ_OVERFLOW_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      prime_q <= prime_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
`ifdef FREQ_OVERFLOW_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.frequency = freq_q;
  assign bus.valid     = valid_q;
`ifdef FREQ_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed, table-driven bench: a 1000-cycle-gate instance for the main behaviour and a
// 20000-cycle-gate instance for saturation.
module tb_freq_gate_counter;
  import freq_pkg::*;

  localparam int unsigned SmallGate = 1000;
  localparam int unsigned BigGate   = 20000;
  localparam int unsigned Sync      = 2;
  localparam int          FirstLat  = 1 + Sync + 1 + SmallGate;
  localparam int          BigLat    = 1 + Sync + 1 + BigGate;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   sig_half = 0;
  bit   sig_level = 1'b0;

  freq_gate_counter_if sif ();
  freq_gate_counter_if bif ();

  freq_gate_counter #(
    .GATE_CYCLES(SmallGate),
    .SYNC_STAGES(Sync)
  ) sdut (
    .clock(clock),
    .reset(reset),
    .bus  (sif)
  );

  freq_gate_counter #(
    .GATE_CYCLES(BigGate),
    .SYNC_STAGES(Sync)
  ) bdut (
    .clock(clock),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clock = ~clock;

  // Stimulus generator: level when sig_half==0, else a square wave of period 2*sig_half.
  initial begin
    logic s;
    int   cnt;
    s = 1'b0;
    cnt = 0;
    sif.signal = 1'b0;
    bif.signal = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (sig_half == 0) begin
        s = sig_level;
        cnt = 0;
      end else if (cnt >= sig_half - 1) begin
        s = ~s;
        cnt = 0;
      end else begin
        cnt++;
      end
      sif.signal = s;
      bif.signal = s;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_valid(input bit big, input int budget, output int cycles);
    logic v;
    cycles = 0;
    v = 1'b0;
    while (!v && cycles < budget) begin
      @(negedge clock);
      cycles++;
      v = big ? bif.valid : sif.valid;
    end
    check("valid arrives", longint'(v), 1);
  endtask

  typedef struct {
    int half;
    bit level;
    int exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    bit any_valid;

    vecs[0] = '{half: 5,  level: 1'b0, exp: 100};
    vecs[1] = '{half: 0,  level: 1'b1, exp: 0};
    vecs[2] = '{half: 2,  level: 1'b0, exp: 250};
    vecs[3] = '{half: 1,  level: 1'b0, exp: 500};
    vecs[4] = '{half: 10, level: 1'b0, exp: 50};

    reset = 1'b1;
    sif.enable = 1'b0;
    bif.enable = 1'b0;
    repeat (3) @(negedge clock);
    check("reset frequency", longint'(sif.frequency), 0);
    check("reset valid", longint'(sif.valid), 0);
    check("reset state", longint'(sdut.state_q), longint'(IDLE));
`ifdef FREQ_OVERFLOW_EN
    check("reset overflow", longint'(sif.overflow), 0);
`endif
    reset = 1'b0;

    // Period-10 wave: first result after prime + one window.
    sig_half = 5;
    repeat (4) @(negedge clock);
    sif.enable = 1'b1;
    wait_valid(1'b0, FirstLat + 50, cyc);
    check("first valid latency", cyc, FirstLat);
    check("first frequency", longint'(sif.frequency), 100);
    @(negedge clock);
    check("valid single pulse", longint'(sif.valid), 0);
    check("held frequency", longint'(sif.frequency), 100);
    wait_valid(1'b0, SmallGate + 50, cyc);
    check("window spacing", cyc, SmallGate - 1);
    check("second frequency", longint'(sif.frequency), 100);

    for (int i = 0; i < 5; i++) begin
      sig_half = vecs[i].half;
      sig_level = vecs[i].level;
      wait_valid(1'b0, SmallGate + 50, cyc);
      wait_valid(1'b0, SmallGate + 50, cyc);
      check($sformatf("vec%0d frequency", i), longint'(sif.frequency), vecs[i].exp);
      check($sformatf("vec%0d window", i), cyc, SmallGate);
      @(negedge clock);
      check($sformatf("vec%0d single valid", i), longint'(sif.valid), 0);
    end

    // One edge whose detection lands in the closing cycle.
    sig_half = 0;
    sig_level = 1'b0;
    wait_valid(1'b0, SmallGate + 50, cyc);
    wait_valid(1'b0, SmallGate + 50, cyc);
    check("quiet window", longint'(sif.frequency), 0);
    repeat (SmallGate - 3) @(posedge clock);
    @(negedge clock);
    sig_level = 1'b1;
    wait_valid(1'b0, SmallGate + 50, cyc);
    check("closing-cycle edge", longint'(sif.frequency), 1);
    wait_valid(1'b0, SmallGate + 50, cyc);
    check("window after closing edge", longint'(sif.frequency), 0);

    // Disable mid-window: no result, previous value held.
    sig_half = 5;
    wait_valid(1'b0, SmallGate + 50, cyc);
    wait_valid(1'b0, SmallGate + 50, cyc);
    check("pre-disable frequency", longint'(sif.frequency), 100);
    repeat (500) @(negedge clock);
    sif.enable = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if (sif.valid) any_valid = 1'b1;
    end
    check("no valid while disabled", longint'(any_valid), 0);
    check("frequency held when disabled", longint'(sif.frequency), 100);
    sif.enable = 1'b1;
    wait_valid(1'b0, FirstLat + 50, cyc);
    check("re-enable latency", cyc, FirstLat);
    check("re-enable frequency", longint'(sif.frequency), 100);

    // Reset mid-window.
    repeat (700) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid reset frequency", longint'(sif.frequency), 0);
    check("mid reset valid", longint'(sif.valid), 0);
    check("mid reset state", longint'(sdut.state_q), longint'(IDLE));
    check("mid reset gate", longint'(sdut.gate_q), 0);
    check("mid reset edge", longint'(sdut.edge_q), 0);
    reset = 1'b0;
    wait_valid(1'b0, FirstLat + 50, cyc);
    check("post reset latency", cyc, FirstLat);
    check("post reset frequency", longint'(sif.frequency), 100);
    sif.enable = 1'b0;

    // Saturation on the long-window instance.
    sig_half = 1;
    repeat (5) @(negedge clock);
    bif.enable = 1'b1;
    wait_valid(1'b1, BigLat + 50, cyc);
    check("big first latency", cyc, BigLat);
    check("saturated frequency", longint'(bif.frequency), 9999);
`ifdef FREQ_OVERFLOW_EN
    check("overflow set", longint'(bif.overflow), 1);
`endif
    sig_half = 2;
    wait_valid(1'b1, BigGate + 50, cyc);
    wait_valid(1'b1, BigGate + 50, cyc);
    check("unsaturated frequency", longint'(bif.frequency), 5000);
`ifdef FREQ_OVERFLOW_EN
    check("overflow clear", longint'(bif.overflow), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
